// File: rtl/dac_mux_pkg.sv
// Shared constants and FSM encoding for the DAC mux scheduler.
package dac_mux_pkg;

    // Default sizing; the top exposes these as overridable parameters.
    localparam int unsigned NUM_CH_DFLT     = 6;
    localparam int unsigned DAC_BITS_DFLT   = 12;
    localparam int unsigned SETTLE_CYC_DFLT = 8;

    // Each serial bit spans BIT_PHASE clk cycles: first half dac_clk low, second half high.
    localparam int unsigned BIT_PHASE = 4;
    localparam int unsigned LOAD_LEN  = 2;
    localparam int unsigned CLEAR_LEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StShift,
        StLdGap,
        StLoad,
        StDone
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1 (mod NUM_CH) and returns a one-hot grant.
module rr_arbiter
    import dac_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DFLT,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // First requester at or after last+1, wrapping; no grant when nothing is requested.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            cand = IDX_W'((int'(last) + i) % int'(NUM_CH));
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dac_mux_scheduler.sv
// Schedules analog-mux channel updates onto one serial DAC: settle, shift, load, ack.
module dac_mux_scheduler
    import dac_mux_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DFLT,
    parameter int unsigned DAC_BITS   = DAC_BITS_DFLT,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DFLT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*DAC_BITS-1:0]   code,
    input  logic                         clr_req,
    output logic [NUM_CH-1:0]            ack,
    output logic                         busy,
    output logic [NUM_CH-1:0]            mux_sel,
    output logic                         dac_clk,
    output logic                         dac_sdi,
    output logic                         dac_ld_n,
    output logic                         dac_clr_n
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIT_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic [BIT_W-1:0]    bit_q;
    logic [1:0]          phase_q;
    logic [DAC_BITS-1:0] shreg_q;
    logic [IDX_W-1:0]    last_q;
    logic                clr_pend_q;

    logic [NUM_CH-1:0]   grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [DAC_BITS-1:0] code_sel;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the code of the channel the arbiter would grant this cycle.
    always_comb begin
        code_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant[i]) begin
                code_sel = code[i*DAC_BITS +: DAC_BITS];
            end
        end
    end

    // Main FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            phase_q    <= '0;
            shreg_q    <= '0;
            last_q     <= IDX_W'(NUM_CH - 1);
            clr_pend_q <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            mux_sel    <= '0;
            dac_clk    <= 1'b1;
            dac_sdi    <= 1'b0;
            dac_ld_n   <= 1'b1;
            dac_clr_n  <= 1'b1;
        end else begin
            ack <= '0;
            // Clear pulses during an update are remembered; repeats collapse into one.
            if (clr_req) begin
                clr_pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (clr_pend_q || clr_req) begin
                        state_q    <= StClear;
                        clr_pend_q <= 1'b0;
                        busy       <= 1'b1;
                        dac_clr_n  <= 1'b0;
                        cnt_q      <= 8'(CLEAR_LEN - 1);
                    end else if (|grant) begin
                        state_q <= StSettle;
                        busy    <= 1'b1;
                        mux_sel <= grant;
                        last_q  <= grant_idx;
                        shreg_q <= code_sel;
                        cnt_q   <= 8'(SETTLE_CYC - 1);
                    end
                end
                StClear: begin
                    if (cnt_q == '0) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        dac_clr_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        // First bit: drop dac_clk and present the MSB together.
                        state_q <= StShift;
                        phase_q <= '0;
                        bit_q   <= BIT_W'(DAC_BITS - 1);
                        dac_clk <= 1'b0;
                        dac_sdi <= shreg_q[DAC_BITS-1];
                        shreg_q <= shreg_q << 1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StShift: begin
                    if (phase_q == 2'(BIT_PHASE - 1)) begin
                        if (bit_q == '0) begin
                            state_q <= StLdGap;
                        end else begin
                            bit_q   <= bit_q - BIT_W'(1);
                            phase_q <= '0;
                            dac_clk <= 1'b0;
                            dac_sdi <= shreg_q[DAC_BITS-1];
                            shreg_q <= shreg_q << 1;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                        dac_clk <= (phase_q >= 2'(BIT_PHASE / 2 - 1));
                    end
                end
                StLdGap: begin
                    state_q  <= StLoad;
                    dac_ld_n <= 1'b0;
                    cnt_q    <= 8'(LOAD_LEN - 1);
                end
                StLoad: begin
                    if (cnt_q == '0) begin
                        state_q  <= StDone;
                        dac_ld_n <= 1'b1;
                        ack      <= mux_sel;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    mux_sel <= '0;
                    dac_sdi <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_mux_scheduler.sv
// Scoreboard bench for dac_mux_scheduler with default parameters.
module tb_dac_mux_scheduler;

    localparam int LATENCY = 60;  // ack cycle, counting the first cycle after grant as 1
    localparam int SETTLE  = 8;
    localparam int NBITS   = 12;
    localparam int LD_LOW  = 2;
    localparam int CLR_LOW = 2;
    localparam int B2B_GAP = 2;   // ack cycle -> one idle cycle -> new grant visible

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  req = '0;
    logic [71:0] code = '0;
    logic        clr_req = 1'b0;
    logic [5:0]  ack;
    logic        busy;
    logic [5:0]  mux_sel;
    logic        dac_clk, dac_sdi, dac_ld_n, dac_clr_n;

    dac_mux_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .code      (code),
        .clr_req   (clr_req),
        .ack       (ack),
        .busy      (busy),
        .mux_sel   (mux_sel),
        .dac_clk   (dac_clk),
        .dac_sdi   (dac_sdi),
        .dac_ld_n  (dac_ld_n),
        .dac_clr_n (dac_clr_n)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit         is_clr;
        logic [5:0] ch;
        logic [11:0] data;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t mk_upd(input int ch, input logic [11:0] d, input int gap);
        exp_t e;
        e.is_clr = 1'b0;
        e.ch     = 6'(1 << ch);
        e.data   = d;
        e.gap    = gap;
        return e;
    endfunction

    function automatic exp_t mk_clr();
        exp_t e;
        e.is_clr = 1'b1;
        e.ch     = '0;
        e.data   = '0;
        e.gap    = -1;
        return e;
    endfunction

    task automatic set_code(input int ch, input logic [11:0] v);
        code[ch*12 +: 12] = v;
    endtask

    // Monitor state
    bit          in_txn = 1'b0;
    int          g_t, fall_t, nbits, ldlow, sdi_bad, unstable, gap_obs;
    int          clr_run = 0, clr_bad = 0, last_ack_t = -1000;
    logic [11:0] cap;
    logic [5:0]  g_mux;
    logic        prev_clk = 1'b1, prev_sdi = 1'b0, prev_busy = 1'b0;
    exp_t        em;

    // Monitor: observe DUT pins at negedge, rebuild transactions, compare against the queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_txn = 1'b0; clr_run = 0; clr_bad = 0; last_ack_t = -1000;
                prev_clk = 1'b1; prev_sdi = 1'b0; prev_busy = 1'b0;
                continue;
            end
            if (!in_txn && mux_sel != '0) begin
                in_txn = 1'b1; g_t = cyc; g_mux = mux_sel; cap = '0; nbits = 0;
                fall_t = -1; ldlow = 0; sdi_bad = 0; unstable = 0;
                gap_obs = cyc - last_ack_t;
            end
            if (in_txn) begin
                if (mux_sel != g_mux || !busy) unstable++;
                if (!prev_clk && dac_clk) begin
                    cap = {cap[10:0], dac_sdi};
                    nbits++;
                end
                if (prev_clk && !dac_clk && fall_t < 0) fall_t = cyc;
                if (!dac_ld_n) ldlow++;
                if (dac_sdi != prev_sdi && prev_busy && busy && !(prev_clk && !dac_clk)) sdi_bad++;
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 0);
                end else begin
                    em = exp_q.pop_front();
                    chk("kind_is_update", 32'(em.is_clr), 0);
                    chk("ack_onehot", 32'(ack), 32'(em.ch));
                    chk("grant_mux_sel", 32'(g_mux), 32'(em.ch));
                    chk("shifted_data", 32'(cap), 32'(em.data));
                    chk("dac_clk_rises", nbits, NBITS);
                    chk("ack_latency", cyc - g_t + 1, LATENCY);
                    chk("settle_len", fall_t - g_t, SETTLE);
                    chk("ld_n_low_len", ldlow, LD_LOW);
                    chk("sdi_change_timing", sdi_bad, 0);
                    chk("mux_busy_stable", unstable, 0);
                    if (em.gap >= 0) chk("ack_to_grant_gap", gap_obs, em.gap);
                end
                in_txn = 1'b0;
                last_ack_t = cyc;
            end
            if (!dac_clr_n) begin
                clr_run++;
                if (mux_sel != '0 || in_txn || !busy) clr_bad++;
            end else if (clr_run > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_clear", clr_run, 0);
                end else begin
                    em = exp_q.pop_front();
                    chk("kind_is_clear", 32'(em.is_clr), 1);
                    chk("clr_n_low_len", clr_run, CLR_LOW);
                    chk("clear_while_idle_mux", clr_bad, 0);
                end
                clr_run = 0;
                clr_bad = 0;
            end
            prev_clk = dac_clk; prev_sdi = dac_sdi; prev_busy = busy;
        end
    end

    task automatic wait_ack(input int ch, input bit drop);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ack[ch]) break;
        end
        chk($sformatf("ack%0d_within_bound", ch), 32'(k < 300), 1);
        if (drop) req[ch] = 1'b0;
    endtask

    task automatic wait_grant(input int ch);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (mux_sel == 6'(1 << ch)) break;
        end
        chk($sformatf("grant%0d_within_bound", ch), 32'(k < 300), 1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_within_bound", 32'(k < 300), 1);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    // Directed stimulus; expected responses are queued before each stimulus is applied.
    initial begin
        code = {12'hFFF, 12'h5F0, 12'h3C3, 12'hA5A, 12'h001, 12'h800};
        repeat (3) @(negedge clk);
        chk("rst_ctl_levels", 32'({dac_clk, dac_sdi, dac_ld_n, dac_clr_n, busy}), 32'h16);
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_ack", 32'(ack), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ctl_levels", 32'({dac_clk, dac_sdi, dac_ld_n, dac_clr_n, busy}), 32'h16);
        chk("idle_mux_sel", 32'(mux_sel), 0);

        // Single update of ch2 with 0xA5A
        exp_q.push_back(mk_upd(2, 12'hA5A, -1));
        req[2] = 1'b1;
        wait_grant(2);
        chk("grant2_mux_sel", 32'(mux_sel), 32'h04);
        wait_ack(2, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // All requests held: round robin from ch0, wrapping back to ch0
        exp_q.push_back(mk_upd(0, 12'h800, -1));
        exp_q.push_back(mk_upd(1, 12'h001, B2B_GAP));
        exp_q.push_back(mk_upd(2, 12'hA5A, B2B_GAP));
        exp_q.push_back(mk_upd(3, 12'h3C3, B2B_GAP));
        exp_q.push_back(mk_upd(4, 12'h5F0, B2B_GAP));
        exp_q.push_back(mk_upd(5, 12'hFFF, B2B_GAP));
        exp_q.push_back(mk_upd(0, 12'h800, B2B_GAP));
        req = 6'b111111;
        for (int c = 0; c < 6; c++) wait_ack(c, 1'b0);
        req = 6'b000001;
        wait_ack(0, 1'b1);

        // Clear pulses during ch1 shift: ch1 finishes, one clear, then ch4
        exp_q.push_back(mk_upd(1, 12'h001, -1));
        exp_q.push_back(mk_clr());
        exp_q.push_back(mk_upd(4, 12'h5F0, -1));
        req[1] = 1'b1;
        wait_grant(1);
        repeat (20) @(negedge clk);
        pulse_clr();
        repeat (3) @(negedge clk);
        pulse_clr();
        req[4] = 1'b1;
        wait_ack(1, 1'b1);
        wait_ack(4, 1'b1);

        // Clear and ch3 request in the same idle cycle
        wait_idle();
        exp_q.push_back(mk_clr());
        exp_q.push_back(mk_upd(3, 12'h3C3, -1));
        clr_req = 1'b1;
        req[3]  = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_ack(3, 1'b1);

        // Code change after grant must not affect the shifted value
        exp_q.push_back(mk_upd(4, 12'h5F0, -1));
        req[4] = 1'b1;
        wait_grant(4);
        repeat (3) @(negedge clk);
        set_code(4, 12'h0AF);
        wait_ack(4, 1'b1);
        set_code(4, 12'h5F0);

        // Reset in the middle of shifting bit 5 of ch2
        exp_q.push_back(mk_upd(2, 12'hA5A, -1));
        req[2] = 1'b1;
        wait_grant(2);
        repeat (29) @(negedge clk);
        chk("pre_reset_clk_low", 32'(dac_clk), 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ctl_levels", 32'({dac_clk, dac_sdi, dac_ld_n, dac_clr_n, busy}), 32'h16);
        chk("midrst_mux_sel", 32'(mux_sel), 0);
        chk("midrst_ack", 32'(ack), 0);
        exp_q.delete();
        req = 6'b000101;
        exp_q.push_back(mk_upd(0, 12'h800, -1));
        exp_q.push_back(mk_upd(2, 12'hA5A, B2B_GAP));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ack(0, 1'b1);
        wait_ack(2, 1'b1);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, want completion", n_chk);
        $fatal(1, "time limit");
    end

endmodule
